vga_capture: RTL and testbench



---
 rtl/vga_pkg.sv | 23 ++
 rtl/sync_edge.sv | 31 +++
 rtl/vga_capture.sv | 149 ++++++++++++++
 tb/tb_vga_capture.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA capture/scan-out types, timing totals and RGB222 byte packing
package vga_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } cap_state_e;

    function automatic int h_total(input int fp, input int sync, input int bp, input int active);
        return fp + sync + bp + active;
    endfunction

    function automatic int v_total(input int fp, input int sync, input int bp, input int active);
        return fp + sync + bp + active;
    endfunction

    function automatic logic [7:0] pack_rgb222(input logic [1:0] r, input logic [1:0] g,
                                               input logic [1:0] b);
        return {2'b00, r, g, b};
    endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - sync input register with leading-edge detect on the registered copy
module sync_edge #(
    parameter logic POL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic lead
);

    logic din_q, din_d;
    logic prev_q, prev_d;

    always_comb begin
        din_d  = din;
        prev_d = din_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            din_q  <= ~POL;
            prev_q <= ~POL;
        end else begin
            din_q  <= din_d;
            prev_q <= prev_d;
        end
    end

    assign lead = (din_q == POL) && (prev_q != POL);

endmodule

// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - VGA receiver writing downscaled RGB222 bytes; VGA_CAPTURE_STATS_EN builds line_len/frame_cnt
module vga_capture
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SYNC_POL    = 0,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hs,
    input  logic              vs,
    input  logic [1:0]        r,
    input  logic [1:0]        g,
    input  logic [1:0]        b,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [7:0]        wdata,
    output logic              locked,
    output logic              err,
    output logic [11:0]       line_len,
    output logic [15:0]       frame_cnt
);

    localparam int          H_TOT    = h_total(H_FP, H_SYNC, H_BP, H_ACTIVE);
    localparam int          V_TOT    = v_total(V_FP, V_SYNC, V_BP, V_ACTIVE);
    localparam logic [11:0] H_LAST   = 12'(H_TOT - 1);
    localparam logic [11:0] H_OVER   = 12'(H_TOT);
    localparam logic [11:0] V_LAST   = 12'(V_TOT - 1);
    localparam logic [11:0] H_START  = 12'(H_SYNC + H_BP);
    localparam logic [11:0] H_END    = 12'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [11:0] V_START  = 12'(V_SYNC + V_BP);
    localparam logic [11:0] V_END    = 12'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [11:0] FB_W     = 12'(H_ACTIVE >> SCALE_SHIFT);
    localparam logic [11:0] SUB_MASK = 12'((1 << SCALE_SHIFT) - 1);

    logic              hs_lead, vs_lead, vc_rst, mismatch, active;
    logic [5:0]        rgb_q, rgb_d;
    logic [11:0]       hc_q, hc_d, vc_q, vc_d, x, y;
    logic              pend_q, pend_d;
    cap_state_e        state_q, state_d;
    logic              err_q, err_d, we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;

    sync_edge #(.POL(SYNC_POL != 0)) u_hs_edge (.clk(clk), .reset(reset), .din(hs), .lead(hs_lead));
    sync_edge #(.POL(SYNC_POL != 0)) u_vs_edge (.clk(clk), .reset(reset), .din(vs), .lead(vs_lead));

    // hc_d/vc_d are the coordinates of the sample currently in the input register
    always_comb begin
        rgb_d  = {r, g, b};
        vc_rst = hs_lead && (pend_q || vs_lead);
        pend_d = pend_q;
        if (vc_rst)       pend_d = 1'b0;
        else if (vs_lead) pend_d = 1'b1;
        hc_d = hs_lead ? 12'd0 : ((hc_q == 12'hFFF) ? hc_q : hc_q + 12'd1);
        vc_d = vc_q;
        if (vc_rst)                          vc_d = 12'd0;
        else if (hs_lead && vc_q != 12'hFFF) vc_d = vc_q + 12'd1;
        mismatch = (hs_lead && hc_q != H_LAST) || (vc_rst && vc_q != V_LAST) || (hc_d == H_OVER);

        x      = hc_d - H_START;
        y      = vc_d - V_START;
        active = (hc_d >= H_START) && (hc_d <= H_END) && (vc_d >= V_START) && (vc_d <= V_END);

        state_d = state_q;
        unique case (state_q)
            SEARCH:  if (vc_rst) state_d = ALIGN;
            ALIGN:   if (mismatch) state_d = SEARCH; else if (vc_rst) state_d = LOCKED;
            LOCKED:  if (mismatch) state_d = SEARCH;
            default: state_d = SEARCH;
        endcase
        err_d = err_q || (mismatch && state_q != SEARCH);

        we_d    = (state_q == LOCKED) && active && ((x & SUB_MASK) == 12'd0) && ((y & SUB_MASK) == 12'd0);
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (we_d) begin
            waddr_d = ADDR_W'({12'd0, y >> SCALE_SHIFT} * {12'd0, FB_W} + {12'd0, x >> SCALE_SHIFT});
            wdata_d = pack_rgb222(rgb_q[5:4], rgb_q[3:2], rgb_q[1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q   <= '0;
            hc_q    <= '0;
            vc_q    <= '0;
            pend_q  <= 1'b0;
            state_q <= SEARCH;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            rgb_q   <= rgb_d;
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            pend_q  <= pend_d;
            state_q <= state_d;
            err_q   <= err_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign we     = we_q;
    assign waddr  = waddr_q;
    assign wdata  = wdata_q;
    assign locked = (state_q == LOCKED);
    assign err    = err_q;

`ifdef VGA_CAPTURE_STATS_EN
    logic [11:0] line_len_q, line_len_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        line_len_d = line_len_q;
        if (hs_lead) line_len_d = (hc_q == 12'hFFF) ? 12'hFFF : hc_q + 12'd1;
        frame_cnt_d = frame_cnt_q + ((state_q == LOCKED && vc_rst) ? 16'd1 : 16'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            line_len_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            line_len_q  <= line_len_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign line_len  = line_len_q;
    assign frame_cnt = frame_cnt_q;
`else
    assign line_len  = '0;
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// tb/tb_vga_capture.sv - directed bench for vga_capture on 14x7 timing, 4x2 framebuffer
module tb_vga_capture;

    localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 2, H_BP = 2;
    localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
    localparam int SCALE_SHIFT = 1, ADDR_W = 3;
    localparam int HT = 14, VT = 7;
`ifdef VGA_CAPTURE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              hs = 1'b1, vs = 1'b1;
    logic [1:0]        r = '0, g = '0, b = '0;
    logic              we, locked, err;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        wdata;
    logic [11:0]       line_len;
    logic [15:0]       frame_cnt;

    int          tests = 0, fails = 0, we_pairs = 0;
    logic        we_prev = 1'b0;
    logic [10:0] wq[$];

    always #5 clk = ~clk;

    vga_capture #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(0), .SCALE_SHIFT(SCALE_SHIFT), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset(reset), .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
        .we(we), .waddr(waddr), .wdata(wdata), .locked(locked), .err(err),
        .line_len(line_len), .frame_cnt(frame_cnt)
    );

    always @(negedge clk) begin
        if (we) wq.push_back({waddr, wdata});
        if (we && we_prev) we_pairs++;
        we_prev = we;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] pix_col(input int v, input int h, input logic [5:0] col,
                                           input int px, input int py);
        int x, y;
        x = h - (H_SYNC + H_BP);
        y = v - (V_SYNC + V_BP);
        if (x < 0 || x >= H_ACTIVE || y < 0 || y >= V_ACTIVE) return 6'd0;
        if (px < 0) return col;
        return (x == px && y == py) ? 6'h3F : 6'd0;
    endfunction

    task automatic step(input int v, input int h, input logic [5:0] col, input int px,
                        input int py, input logic rst);
        logic [5:0] c;
        c = pix_col(v, h, col, px, py);
        @(negedge clk);
        reset = rst;
        hs = !(h < H_SYNC);
        vs = !(v < V_SYNC);
        {r, g, b} = c;
    endtask

    task automatic run_frame(input logic [5:0] col);
        for (int v = 0; v < VT; v++)
            for (int h = 0; h < HT; h++) step(v, h, col, -1, -1, 1'b0);
    endtask

    task automatic check_writes(input string tag, input logic [7:0] d);
        logic [10:0] got;
        check({tag, "_count"}, wq.size(), 8);
        for (int i = 0; i < 8; i++) begin
            got = (i < wq.size()) ? wq[i] : 11'h7FF;
            check($sformatf("%s_wr%0d", tag, i), got, {i[2:0], d});
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"}, we, 0);
        check({tag, "_waddr"}, waddr, 0);
        check({tag, "_wdata"}, wdata, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_line_len"}, line_len, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;

        // frame 1 runs in ALIGN, frame 2 locks on its first vc reset
        run_frame(6'b101101);
        check("f1_locked", locked, 0);
        wq.delete();
        for (int v = 0; v < VT; v++)
            for (int h = 0; h < HT; h++) begin
                step(v, h, 6'b101101, -1, -1, 1'b0);
                if (v == 0 && h == 1) check("lock_rise_early", locked, 0);
                if (v == 0 && h == 2) check("lock_rise", locked, 1);
            end
        check_writes("clean", 8'h2D);
        check("clean_err", err, 0);
        check("line_len", line_len, STATS ? 14 : 0);
        check("fc_align", frame_cnt, 0);

        // single lit pixel at x=2, y=2
        for (int v = 0; v < VT; v++)
            for (int h = 0; h < HT; h++) begin
                step(v, h, 6'd0, 2, 2, 1'b0);
                if (v == 4 && h == 7) check("probe_we_early", we, 0);
                if (v == 4 && h == 8) begin
                    check("probe_we", we, 1);
                    check("probe_waddr", waddr, 5);
                    check("probe_wdata", wdata, 8'h3F);
                end
            end
        check("fc1", frame_cnt, STATS ? 1 : 0);
        run_frame(6'b010110);
        check("fc2", frame_cnt, STATS ? 2 : 0);
        run_frame(6'b101101);
        check("fc3", frame_cnt, STATS ? 3 : 0);
        check("line_len2", line_len, STATS ? 14 : 0);

        // line 3 is 15 clocks long
        for (int v = 0; v < VT; v++)
            for (int h = 0; h < ((v == 3) ? HT + 1 : HT); h++) begin
                step(v, h, 6'b101101, -1, -1, 1'b0);
                if (v == 4 && h == 0) check("long_locked_hold", locked, 1);
                if (v == 4 && h == 1) begin
                    check("long_locked_fall", locked, 0);
                    check("long_err", err, 1);
                    wq.delete();
                end
            end
        check("long_no_writes", wq.size(), 0);
        run_frame(6'b101101);
        check("relock1_align", locked, 0);
        run_frame(6'b101101);
        check("relock1", locked, 1);

        // hs held inactive for 20 clocks on line 3
        for (int v = 0; v < VT; v++)
            for (int h = 0; h < ((v == 3) ? H_SYNC + 20 : HT); h++) begin
                step(v, h, 6'b101101, -1, -1, 1'b0);
                if (v == 3 && h == 15) check("hold_locked_hold", locked, 1);
                if (v == 3 && h == 16) check("hold_locked_fall", locked, 0);
            end
        run_frame(6'b101101);
        check("relock2_align", locked, 0);
        run_frame(6'b101101);
        check("relock2", locked, 1);

        // reset while the stored pixel x=2, y=0 is on the pins
        for (int v = 0; v < VT; v++)
            for (int h = 0; h < HT; h++) begin
                step(v, h, 6'b101101, -1, -1, (v == 2 && h == 6));
                if (v == 2 && h == 7) check_reset_values("midrst");
                if (v == 2 && h == 8) check("midrst_drop", we, 0);
            end
        check("midrst_search", locked, 0);
        run_frame(6'b101101);
        check("relock3_align", locked, 0);
        wq.delete();
        run_frame(6'b101101);
        check("relock3", locked, 1);
        check_writes("relock3", 8'h2D);
        check("final_err", err, 0);
        check("we_pairs", we_pairs, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
